// File: rtl/gol_pkg.sv
// gol_pkg: shared grid geometry, fetch FSM encoding and species palette
// Contents: GRID_W/CELL_W geometry, fetch_state_t FSM states, PALETTE species->rgb table
package gol_pkg;
  localparam int GRID_W = 256;
  localparam int CELL_W = 4;
  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DRAIN} fetch_state_t;
  // index = species code; 8..15 flag illegal codes in grey
  localparam logic [15:0][11:0] PALETTE = {{8{12'h888}}, 12'hFFF, 12'hF0F, 12'h0FF,
                                           12'hFF0, 12'h00F, 12'h0F0, 12'hF00, 12'h000};
endpackage

// File: rtl/gol_palette.sv
// gol_palette: registered species-to-rgb lookup, second stage of the pixel pipeline
// Ports: clk, rst_n (sync active-low), i_vis (pixel visible), i_cell (species), o_rgb (4:4:4 colour)
module gol_palette
  import gol_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vis,
  input  logic [CELL_W-1:0] i_cell,
  output logic [11:0]       o_rgb
);
  logic [11:0] r_rgb;
  always_ff @(posedge clk)
    r_rgb <= (!rst_n || !i_vis) ? 12'h000 : PALETTE[i_cell];
  assign o_rgb = r_rgb;
endmodule

// File: rtl/gol_scanline_fetch.sv
// gol_scanline_fetch: prefetches one grid row per line into a ping-pong buffer and paints it
// Ports: clk, rst_n (sync active-low); video timing video_sof/line_start/vpos/hpos/de;
//        ram_select/init_done from the update engine; dout_bank0/1 read data (1-cycle latency);
//        rd_addr {row,col} read address; rgb/de_out pixel out (2-cycle lag); fetch_overrun sticky error
module gol_scanline_fetch
  import gol_pkg::*;
#(
  parameter int H_OFFSET   = 128,
  parameter int V_OFFSET   = 104,
  parameter int SCALE_LOG2 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_sof,
  input  logic              line_start,
  input  logic [11:0]       vpos,
  input  logic [11:0]       hpos,
  input  logic              de,
  input  logic              ram_select,
  input  logic              init_done,
  input  logic [CELL_W-1:0] dout_bank0,
  input  logic [CELL_W-1:0] dout_bank1,
  output logic [15:0]       rd_addr,
  output logic [11:0]       rgb,
  output logic              de_out,
  output logic              fetch_overrun
);
  localparam int SPAN = GRID_W << SCALE_LOG2;
  logic [CELL_W-1:0] r_buf [0:2*GRID_W-1];
  fetch_state_t r_state, w_state_n;
  logic [15:0] r_rd_addr;
  logic        r_bank, r_wr_en, r_front, r_front_valid, r_back_done, r_overrun, r_line_in_win;
  logic [7:0]  r_wr_col, r_front_row, r_back_row;
  logic        r_s1_vis, r_s1_de, r_de_out;
  logic [CELL_W-1:0] r_s1_cell;
  logic [12:0] w_v, w_t, w_h, w_trel;
  logic [11:0] w_hrel;
  logic [7:0]  w_row, w_col, w_front_row_n;
  logic        w_v_in, w_t_in, w_h_in, w_swap, w_front_valid_n, w_start, w_last;
  logic [CELL_W-1:0] w_dout;
  logic        w_unused;
  assign w_unused = video_sof;
  assign w_v    = {1'b0, vpos};
  assign w_t    = w_v + 13'd1;
  assign w_h    = {1'b0, hpos};
  assign w_v_in = (w_v >= 13'(V_OFFSET)) && (w_v < 13'(V_OFFSET + SPAN));
  assign w_t_in = (w_t >= 13'(V_OFFSET)) && (w_t < 13'(V_OFFSET + SPAN));
  assign w_h_in = (w_h >= 13'(H_OFFSET)) && (w_h < 13'(H_OFFSET + SPAN));
  assign w_trel = w_t - 13'(V_OFFSET);
  assign w_row  = 8'(w_trel >> SCALE_LOG2);
  assign w_hrel = hpos - 12'(H_OFFSET);
  assign w_col  = 8'(w_hrel >> SCALE_LOG2);
  assign w_last = r_rd_addr[7:0] == 8'hFF;
  assign w_dout = r_bank ? dout_bank1 : dout_bank0;
  // the skip test must see the front tag as it will be after this line's swap
  assign w_swap          = line_start && r_back_done;
  assign w_front_valid_n = w_swap || r_front_valid;
  assign w_front_row_n   = w_swap ? r_back_row : r_front_row;
  assign w_start = line_start && w_t_in && !(w_front_valid_n && w_row == w_front_row_n);
  always_ff @(posedge clk)
    r_state <= !rst_n ? F_IDLE : w_state_n;
  // any line_start overrides the current state: abort if busy, then re-evaluate
  always_comb begin
    w_state_n = r_state;
    if (line_start)
      w_state_n = w_start ? F_FETCH : F_IDLE;
    else if (r_state == F_FETCH && w_last)
      w_state_n = F_DRAIN;
    else if (r_state == F_DRAIN)
      w_state_n = F_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_addr     <= '0;
      r_bank        <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_col      <= '0;
      r_front       <= 1'b0;
      r_front_valid <= 1'b0;
      r_front_row   <= '0;
      r_back_row    <= '0;
      r_back_done   <= 1'b0;
      r_overrun     <= 1'b0;
      r_line_in_win <= 1'b0;
    end else begin
      // data for the address issued this cycle returns next cycle
      r_wr_en  <= r_state == F_FETCH && !line_start;
      r_wr_col <= r_rd_addr[7:0];
      if (r_state == F_FETCH && !line_start && !w_last)
        r_rd_addr <= r_rd_addr + 16'd1;
      if (r_state == F_DRAIN && !line_start)
        r_back_done <= 1'b1;
      if (line_start) begin
        r_line_in_win <= w_v_in;
        r_back_done   <= 1'b0;
        if (r_state != F_IDLE)
          r_overrun <= 1'b1;
        if (r_back_done) begin
          r_front       <= ~r_front;
          r_front_row   <= r_back_row;
          r_front_valid <= 1'b1;
        end
        if (w_start) begin
          r_rd_addr  <= {w_row, 8'd0};
          r_bank     <= ram_select;
          r_back_row <= w_row;
        end
      end
    end
  end
  // buffer contents survive reset; the front tag alone decides visibility
  always_ff @(posedge clk)
    if (r_wr_en)
      r_buf[{~r_front, r_wr_col}] <= w_dout;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vis  <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_cell <= '0;
      r_de_out  <= 1'b0;
    end else begin
      r_s1_vis  <= de && w_h_in && r_line_in_win && init_done && r_front_valid;
      r_s1_de   <= de;
      r_s1_cell <= r_buf[{r_front, w_col}];
      r_de_out  <= r_s1_de;
    end
  end
  gol_palette u_palette (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vis  (r_s1_vis),
    .i_cell (r_s1_cell),
    .o_rgb  (rgb)
  );
  assign rd_addr       = r_rd_addr;
  assign de_out        = r_de_out;
  assign fetch_overrun = r_overrun;
endmodule

// File: tb/tb_gol_scanline_fetch.sv
// tb_gol_scanline_fetch: directed self-checking bench for gol_scanline_fetch
module tb_gol_scanline_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, video_sof, line_start, de, ram_select, init_done;
  logic [11:0] vpos, hpos, rgb;
  logic [3:0]  dout_bank0, dout_bank1;
  logic [15:0] rd_addr;
  logic de_out, fetch_overrun;
  int checks = 0;
  int failures = 0;
  logic [3:0] mem0 [0:65535];
  logic [3:0] mem1 [0:65535];
  gol_scanline_fetch dut (
    .clk(clk), .rst_n(rst_n), .video_sof(video_sof), .line_start(line_start),
    .vpos(vpos), .hpos(hpos), .de(de), .ram_select(ram_select), .init_done(init_done),
    .dout_bank0(dout_bank0), .dout_bank1(dout_bank1), .rd_addr(rd_addr), .rgb(rgb),
    .de_out(de_out), .fetch_overrun(fetch_overrun)
  );
  always @(posedge clk) begin
    dout_bank0 <= mem0[rd_addr];
    dout_bank1 <= mem1[rd_addr];
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic [11:0] v);
    vpos = v;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask
  task automatic pix(input string tag, input logic [11:0] h, input logic [11:0] exp);
    hpos = h;
    de = 1'b1;
    step();
    de = 1'b0;
    step();
    chk(tag, {4'h0, rgb}, {4'h0, exp});
    chk({tag, "_de"}, {15'd0, de_out}, 16'd1);
  endtask
  initial begin
    rst_n = 1'b0; video_sof = 1'b0; line_start = 1'b0; de = 1'b0;
    ram_select = 1'b1; init_done = 1'b1; vpos = '0; hpos = '0;
    for (int a = 0; a < 65536; a++) begin
      mem0[a] = 4'd5;
      mem1[a] = 4'd3;
    end
    for (int c = 0; c < 256; c++) begin
      mem1[256 + c]  = 4'd2;
      mem1[512 + c]  = 4'd7;
      mem1[1024 + c] = 4'd1;
    end
    mem1[16'h00FF] = 4'd9;
    step(3);
    chk("rst_addr", rd_addr, 16'h0000);
    chk("rst_rgb", {4'h0, rgb}, 16'h0000);
    chk("rst_de", {15'd0, de_out}, 16'd0);
    chk("rst_ovr", {15'd0, fetch_overrun}, 16'd0);
    rst_n = 1'b1;
    step();
    video_sof = 1'b1;
    pulse(12'd103);
    video_sof = 1'b0;
    chk("addr_first", rd_addr, 16'h0000);
    for (int i = 1; i < 256; i++) begin
      step();
      chk("addr_step", rd_addr, 16'(i));
    end
    step(3);
    pix("black_invalid", 12'd128, 12'h000);
    pulse(12'd104);
    step(5);
    chk("skip_104", rd_addr, 16'h00FF);
    pix("row0_128", 12'd128, 12'h00F);
    pix("row0_129", 12'd129, 12'h00F);
    pix("col255", 12'd639, 12'h888);
    pix("hpos640", 12'd640, 12'h000);
    pix("hpos127", 12'd127, 12'h000);
    hpos = 12'd130;
    de = 1'b0;
    step(2);
    chk("de_low_rgb", {4'h0, rgb}, 16'h0000);
    chk("de_low_de", {15'd0, de_out}, 16'd0);
    pulse(12'd105);
    chk("row1_addr", rd_addr, 16'h0100);
    pix("rep_105", 12'd128, 12'h00F);
    step(260);
    pulse(12'd106);
    pix("row1", 12'd128, 12'h0F0);
    step(3);
    chk("skip_106", rd_addr, 16'h01FF);
    pulse(12'd107);
    chk("row2_addr", rd_addr, 16'h0200);
    step(99);
    chk("mid_fetch", rd_addr, 16'h0263);
    pulse(12'd108);
    chk("ovr_set", {15'd0, fetch_overrun}, 16'd1);
    chk("refetch", rd_addr, 16'h0200);
    pix("no_swap", 12'd128, 12'h0F0);
    step(260);
    chk("ovr_sticky", {15'd0, fetch_overrun}, 16'd1);
    pulse(12'd109);
    chk("ovr_sticky2", {15'd0, fetch_overrun}, 16'd1);
    chk("row3_addr", rd_addr, 16'h0300);
    pix("row2", 12'd128, 12'hFFF);
    init_done = 1'b0;
    pix("init_low", 12'd128, 12'h000);
    step(260);
    pulse(12'd110);
    pix("init_low2", 12'd128, 12'h000);
    init_done = 1'b1;
    pulse(12'd111);
    chk("row4_addr", rd_addr, 16'h0400);
    pix("init_high", 12'd128, 12'h00F);
    step(50);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_addr", rd_addr, 16'h0000);
    chk("mrst_rgb", {4'h0, rgb}, 16'h0000);
    chk("mrst_de", {15'd0, de_out}, 16'd0);
    chk("mrst_ovr", {15'd0, fetch_overrun}, 16'd0);
    step(5);
    chk("mrst_idle", rd_addr, 16'h0000);
    pulse(12'd112);
    chk("row4_again", rd_addr, 16'h0400);
    pix("post_rst_black", 12'd128, 12'h000);
    step(260);
    pix("still_black", 12'd128, 12'h000);
    ram_select = 1'b0;
    pulse(12'd113);
    ram_select = 1'b1;
    chk("row5_addr", rd_addr, 16'h0500);
    pix("row4", 12'd128, 12'hF00);
    step(260);
    pulse(12'd114);
    pix("bank0", 12'd128, 12'h0FF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
